mem_access_ctrl: RTL and testbench

Memory access controller holding the LC-3 MAR/MDR pair. It captures the effective address produced by the address block into MAR and runs a single read or write transaction against a ready/valid-style memory port. Results land in MDR, and a one-cycle R (ready) pulse signals completion to the control FSM. It sits between the datapath bus/EAB outputs and the memory subsystem.

---
 rtl/mem_access_ctrl_if.sv | 20 ++
 rtl/mem_access_ctrl.sv | 120 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Memory-side port of the MAR/MDR access controller.
// The controller drives the master side; the memory subsystem drives the slave side.
interface mem_access_ctrl_if;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        memEn;
  logic        memWe;
  logic        memRdy;
  logic [15:0] memRdata;

  modport master (
    output memAddr, memWdata, memEn, memWe,
    input  memRdy, memRdata
  );

  modport slave (
    input  memAddr, memWdata, memEn, memWe,
    output memRdy, memRdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3 memory access controller: holds MAR/MDR and runs one read or write
// against a ready/valid memory port, then pulses R for one cycle.
// Optional feature macro: LC3_ACV_EN (user-mode access control violation check).
// Without it, privMode is ignored and every address is accessed.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               eabIn,
  input  logic [15:0]               busIn,
  input  logic                      ldMAR,
  input  logic                      ldMDR,
  input  logic                      start,
  input  logic                      rw,
  input  logic                      privMode,
  mem_access_ctrl_if.master         mem,
  output logic [15:0]               mar,
  output logic [15:0]               mdr,
  output logic                      busy,
  output logic                      R,
  output logic                      err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} stateT;

  stateT         state, nextState;
  logic          rwQ;
  logic [CW-1:0] waitCnt;
  logic [15:0]   effAddr;
  logic          acvFault;
  logic          memEnC, memWeC, busyC, rC;

  // A start coinciding with ldMAR must use the freshly presented address.
  assign effAddr = ldMAR ? eabIn : mar;

`ifdef LC3_ACV_EN
  // User mode may not touch system space below 0x3000 or the device page at 0xFE00+.
  assign acvFault = privMode && ((effAddr < 16'h3000) || (effAddr >= 16'hFE00));
`else
  logic unusedPriv;
  assign unusedPriv = privMode;
  assign acvFault   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic: memRdy has priority over the timeout on the last wait cycle.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = acvFault ? DONE : REQ;
      REQ:     if (mem.memRdy || (waitCnt == LAST_WAIT)) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decode the state register only, so they carry no input-to-output path.
  always_comb begin
    memEnC = 1'b0;
    memWeC = 1'b0;
    busyC  = 1'b1;
    rC     = 1'b0;
    unique case (state)
      IDLE:    busyC = 1'b0;
      REQ:     begin memEnC = 1'b1; memWeC = rwQ; end
      DONE:    rC = 1'b1;
      default: busyC = 1'b0;
    endcase
  end

  assign mem.memEn    = memEnC;
  assign mem.memWe    = memWeC;
  assign mem.memAddr  = mar;
  assign mem.memWdata = mdr;
  assign busy         = busyC;
  assign R            = rC;

  // MAR/MDR, direction latch, wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      mar     <= '0;
      mdr     <= '0;
      rwQ     <= 1'b0;
      err     <= 1'b0;
      waitCnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ldMAR) mar <= eabIn;
          if (ldMDR) mdr <= busIn;
          if (start) begin
            rwQ     <= rw;
            err     <= acvFault;
            waitCnt <= '0;
          end
        end
        REQ: begin
          if (mem.memRdy) begin
            if (!rwQ) mdr <= mem.memRdata;
          end else if (waitCnt == LAST_WAIT) begin
            err <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level model:
// each access is predicted from its memory delay, direction and privilege.
module tb_mem_access_ctrl;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] eabIn, busIn;
  logic        ldMAR, ldMDR, start, rw, privMode;
  logic [15:0] mar, mdr;
  logic        busy, R, err;

  mem_access_ctrl_if memIf();

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .eabIn(eabIn), .busIn(busIn),
    .ldMAR(ldMAR), .ldMDR(ldMDR), .start(start), .rw(rw), .privMode(privMode),
    .mem(memIf), .mar(mar), .mdr(mdr), .busy(busy), .R(R), .err(err)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;
  logic [15:0] mMar, mMdr;
  logic        mErr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quietIns();
    ldMAR = 1'b0; ldMDR = 1'b0; start = 1'b0;
    eabIn = 16'($urandom); busIn = 16'($urandom); rw = 1'($urandom);
    memIf.memRdy = 1'b0; memIf.memRdata = 16'($urandom);
  endtask

  function automatic logic acvHit(input logic p, input logic [15:0] a);
`ifdef LC3_ACV_EN
    return p && ((a < 16'h3000) || (a >= 16'hFE00));
`else
    return 1'b0 & p & a[0];
`endif
  endfunction

  // One complete access: load cycle, start, wait for R, then the R cycle.
  task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wdat,
                        input logic [15:0] rdat, input int delay, input logic priv,
                        input logic ldWithStart, input logic noise);
    int lat, enCnt, expLat, expEn;
    logic done, fault, tmo;
    quietIns();
    ldMDR = 1'b1; busIn = wdat;
    if (!ldWithStart) begin ldMAR = 1'b1; eabIn = addr; end
    step();
    mMdr = wdat;
    if (!ldWithStart) mMar = addr;

    quietIns();
    start = 1'b1; rw = wr; privMode = priv;
    if (ldWithStart) begin ldMAR = 1'b1; eabIn = addr; end
    step();
    mMar   = addr;
    fault  = acvHit(priv, addr);
    tmo    = !fault && (delay >= T);
    expLat = fault ? 1 : (tmo ? T + 1 : delay + 2);
    expEn  = fault ? 0 : (tmo ? T : delay + 1);
    chk("err_at_start", err, fault);
    chk("mar_loaded", mar, addr);

    lat = 0; enCnt = 0; done = 1'b0;
    while (!done && lat < T + 6) begin
      lat++;
      quietIns();
      if (R) begin
        done = 1'b1;
      end else begin
        chk("busy", busy, 1);
        if (memIf.memEn) begin
          enCnt++;
          chk("memAddr_held", memIf.memAddr, addr);
          chk("memWdata_held", memIf.memWdata, mMdr);
          chk("memWe", memIf.memWe, wr);
          memIf.memRdy = (enCnt - 1 == delay);
          if (memIf.memRdy) memIf.memRdata = rdat;
        end
        if (noise) begin
          ldMAR = 1'($urandom); ldMDR = 1'($urandom); start = 1'($urandom);
        end
        step();
      end
    end
    if (!done) chk("R_never_seen", 0, 1);

    if (!fault && !tmo && !wr) mMdr = rdat;
    mErr = fault || tmo;
    chk("latency", lat, expLat);
    chk("memEn_cycles", enCnt, expEn);
    chk("mdr", mdr, mMdr);
    chk("mar", mar, mMar);
    chk("err", err, mErr);
    chk("memEn_in_R", memIf.memEn, 0);

    // A start or stray memRdy during the R cycle must be ignored.
    start = 1'($urandom); ldMAR = 1'($urandom); memIf.memRdy = 1'($urandom);
    step();
    chk("R_single", R, 0);
    chk("idle_after_R", busy, 0);
    chk("mar_after_R", mar, mMar);
    quietIns();
  endtask

  task automatic resetMidAccess();
    quietIns();
    ldMAR = 1'b1; eabIn = 16'h4321; ldMDR = 1'b1; busIn = 16'h5A5A;
    step();
    quietIns();
    start = 1'b1; rw = 1'b0; privMode = 1'b0;
    step();
    quietIns();
    step();
    chk("rst_pre_memEn", memIf.memEn, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_memEn", memIf.memEn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mar", mar, 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_R", R, 0);
    chk("rst_err", err, 0);
    step();
    chk("rst_no_R", R, 0);
    mMar = 16'h0; mMdr = 16'h0; mErr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; privMode = 1'b0;
    quietIns();
    step(); step();
    chk("reset_mar", mar, 0);
    chk("reset_mdr", mdr, 0);
    chk("reset_memEn", memIf.memEn, 0);
    chk("reset_memWe", memIf.memWe, 0);
    chk("reset_memAddr", memIf.memAddr, 0);
    chk("reset_memWdata", memIf.memWdata, 0);
    chk("reset_R", R, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    reset = 1'b0;
    mMar = 16'h0; mMdr = 16'h0; mErr = 1'b0;
    step();

    // Directed cases: fast read, write with waits, timeout, recovery, noise, ACV address.
    access(1'b0, 16'h3005, 16'h0000, 16'hBEEF, 0, 1'b0, 1'b0, 1'b0);
    access(1'b1, 16'h4000, 16'h1234, 16'hDEAD, 3, 1'b0, 1'b0, 1'b0);
    access(1'b0, 16'h5000, 16'h7777, 16'hCAFE, 100, 1'b0, 1'b0, 1'b0);
    access(1'b0, 16'h5001, 16'h0101, 16'h2468, 1, 1'b0, 1'b1, 1'b0);
    access(1'b0, 16'h6000, 16'h1111, 16'h9999, 2, 1'b0, 1'b0, 1'b1);
    access(1'b0, 16'hFE00, 16'h2222, 16'h3333, 0, 1'b1, 1'b0, 1'b0);
    access(1'b0, 16'hFE00, 16'h2222, 16'h4444, 0, 1'b0, 1'b0, 1'b0);
    access(1'b1, 16'h2FFF, 16'hABCD, 16'h0000, T - 1, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      logic [15:0] edges [4];
      edges[0] = 16'h2FFF; edges[1] = 16'h3000; edges[2] = 16'hFDFF; edges[3] = 16'hFE00;
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
      access(1'($urandom), a, 16'($urandom), 16'($urandom), $urandom_range(0, T + 1),
             1'($urandom), 1'($urandom), 1'($urandom));
    end

    resetMidAccess();
    access(1'b0, 16'h3100, 16'h0F0F, 16'h1357, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
